flaf_nonl_tap_mac: RTL
======================

FLAF_NONL_TAP_MAC -- requirements
Module: flaf_nonl_tap_mac

Interface
REQ-001 SHALL have parameter Q_ORD, default 7, number of expanded features per sample.
REQ-002 SHALL have parameter WIDTH, default 16, width of feature, weight and output words.
REQ-003 SHALL have parameter N_TAPS, default 4, number of samples held in the delay line.
REQ-004 SHALL have parameter QP, default 15, feature fraction bits; weights carry 12 fraction bits, output 12 fraction bits.
REQ-005 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-007 SHALL have port phi_valid, input, 1, expanded sample present.
REQ-008 SHALL have port phi_in_packed, input, Q_ORD*WIDTH, signed features; feature k at bits [WIDTH*k +: WIDTH], k=0 is raw x.
REQ-009 SHALL have port phi_ready, output, 1, block can accept a sample.
REQ-010 SHALL have port w_wr_en, input, 1, weight write strobe.
REQ-011 SHALL have port w_wr_addr, input, clog2(N_TAPS*Q_ORD), address = tap*Q_ORD + k.
REQ-012 SHALL have port w_wr_data, input, WIDTH, signed weight.
REQ-013 SHALL have port y_out, output, WIDTH, signed filter output.
REQ-014 SHALL have port y_valid, output, 1, y_out valid.
REQ-015 SHALL have port y_ready, input, 1, consumer accepts y_out.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-017 SHALL assert phi_ready only in IDLE; sample accepted when phi_valid and phi_ready high on a rising edge.
REQ-018 SHALL on acceptance shift the delay line: tap n+1 <= tap n, tap 0 <= phi_in_packed, oldest tap discarded; clear accumulator; enter BUSY.
REQ-019 SHALL in BUSY perform exactly one signed WIDTH x WIDTH multiply-accumulate per cycle, N_TAPS*Q_ORD cycles, address order 0 upward.
REQ-020 SHALL size the accumulator 2*WIDTH + clog2(N_TAPS*Q_ORD) bits; no intermediate overflow possible.
REQ-021 SHALL after the last MAC form y = (acc + 2^(QP-1)) >>> QP (round half up), reduce to WIDTH per REQ-033/034, register into y_out, enter DONE.
REQ-022 SHALL assert y_valid throughout DONE only; y_valid first high N_TAPS*Q_ORD+1 cycles after the acceptance edge (29 at defaults).
REQ-023 SHALL hold y_out and y_valid stable in DONE until y_ready high; then return to IDLE next cycle, phi_ready high that cycle.
REQ-024 SHALL retain y_out after leaving DONE until the next DONE.
REQ-025 SHALL write weights only in IDLE; w_wr_en in BUSY or DONE ignored, weight array unchanged.
REQ-026 SHALL, when w_wr_en and sample acceptance coincide in IDLE, apply both; the accepted sample's MAC uses the newly written weight.
REQ-027 SHALL ignore w_wr_addr >= N_TAPS*Q_ORD.

Reset
REQ-028 SHALL on reset low force state IDLE, phi_ready 1, y_valid 0, y_out 0, accumulator 0, counter 0.
REQ-029 SHALL clear all delay-line taps and all weights to 0 on reset.
REQ-030 SHALL abandon any in-flight BUSY or DONE computation on reset; no y_valid pulse is produced for it.
REQ-031 SHALL release reset synchronously at the block's first rising edge after deassertion; first acceptance possible on that edge.

Configuration
REQ-032 SHALL use macro FLAF_OUT_SAT_EN.
REQ-033 SHALL with FLAF_OUT_SAT_EN defined saturate the rounded result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-034 SHALL without FLAF_OUT_SAT_EN keep the low WIDTH bits of the rounded result (two's-complement wrap).

Verification
REQ-035 SHALL cover: weight addr 0 = 4096, all others 0; phi0 = 16384, other features 0 -> y_out = 2048, y_valid 29 cycles after acceptance.
REQ-036 SHALL cover: weight addr 7 (tap 1, k 0) = 4096; sample A phi0 = 8192, then sample B all zeros -> first y_out = 0, second y_out = 1024.
REQ-037 SHALL cover: all weights 32767, all taps filled with 32767 -> y_out = 32767 with FLAF_OUT_SAT_EN, y_out = -56 without.
REQ-038 SHALL cover: y_ready held low 10 cycles in DONE -> y_out/y_valid stable, phi_ready 0, phi_valid ignored; y_ready high -> IDLE next cycle.
REQ-039 SHALL cover: w_wr_en to addr 0 during BUSY -> result unchanged versus no write; readback via later sample shows old weight.
REQ-040 SHALL cover: reset low at BUSY cycle 10 -> y_valid 0, phi_ready 1 after release; next sample with zero weights -> y_out = 0.

Source files
------------

// File: rtl/flaf_nonl_tap_mac.sv
// Nonlinear (FLAF) tap multiply-accumulate: a delay line of expanded samples, one MAC per cycle.
// Define FLAF_OUT_SAT_EN to saturate the output word; otherwise the rounded result wraps.
module flaf_nonl_tap_mac #(
  parameter int unsigned Q_ORD  = 7,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned N_TAPS = 4,
  parameter int unsigned QP     = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             phi_valid,
  input  logic [Q_ORD*WIDTH-1:0]           phi_in_packed,
  output logic                             phi_ready,
  input  logic                             w_wr_en,
  input  logic [$clog2(N_TAPS*Q_ORD)-1:0]  w_wr_addr,
  input  logic [WIDTH-1:0]                 w_wr_data,
  output logic [WIDTH-1:0]                 y_out,
  output logic                             y_valid,
  input  logic                             y_ready
);

  localparam int NW      = N_TAPS * Q_ORD;
  localparam int ADDR_W  = $clog2(NW);
  localparam int CW      = $clog2(NW + 1);
  localparam int AW      = 2 * WIDTH + $clog2(NW);

  localparam logic [ADDR_W:0]        NW_L    = NW[ADDR_W:0];
  localparam logic [CW-1:0]          CNT_END = NW[CW-1:0];
  localparam logic signed [AW-1:0]   RND     = AW'(64'sd1 <<< (QP - 1));

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]        y_q, y_d;

  // Flat storage: entry tap*Q_ORD + k, matching the weight address map.
  logic signed [WIDTH-1:0] feat_q [NW];
  logic signed [WIDTH-1:0] wgt_q  [NW];

  logic                    accept;
  logic                    w_write;
  logic                    mac_last;
  logic [ADDR_W-1:0]       mac_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]    rnd;
  logic [WIDTH-1:0]        y_rnd;

  assign phi_ready = (state_q == StIdle);
  assign y_valid   = (state_q == StDone);
  assign y_out     = y_q;

  assign accept   = phi_valid & phi_ready;
  assign w_write  = w_wr_en & phi_ready & ({1'b0, w_wr_addr} < NW_L);
  assign mac_idx  = cnt_q[ADDR_W-1:0];
  assign mac_last = (cnt_q == CNT_END);
  assign prod     = feat_q[mac_idx] * wgt_q[mac_idx];
  assign rnd      = acc_q + RND;

`ifdef FLAF_OUT_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] Y_MIN = AW'(-(64'sd1 <<< (WIDTH - 1)));

  logic signed [AW-1:0] shf;
  assign shf = rnd >>> QP;

  always_comb begin
    y_rnd = shf[WIDTH-1:0];
    if (shf > Y_MAX) begin
      y_rnd = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shf < Y_MIN) begin
      y_rnd = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign y_rnd = WIDTH'(rnd >>> QP);
`endif

  // BUSY runs NW MAC cycles (cnt 0..NW-1) plus one cycle to round and register the output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StBusy: begin
        if (mac_last) begin
          y_d     = y_rnd;
          state_d = StDone;
        end else begin
          acc_d = acc_q + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (y_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  // A write coinciding with acceptance lands before the first MAC reads the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin
        feat_q[i] <= '0;
        wgt_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = NW - 1; i >= int'(Q_ORD); i--) begin
          feat_q[i] <= feat_q[i-int'(Q_ORD)];
        end
        for (int k = 0; k < int'(Q_ORD); k++) begin
          feat_q[k] <= phi_in_packed[WIDTH*k +: WIDTH];
        end
      end
      if (w_write) begin
        wgt_q[w_wr_addr] <= w_wr_data;
      end
    end
  end

endmodule
